// File: rtl/gauss_window_gen_pkg.sv
// Shared constants and FSM state type for the Gaussian 5x14 window producer.
package gauss_window_gen_pkg;
   localparam int GW_ROWS       = 5;
   localparam int GW_COLS       = 14;
   localparam int GW_COL_STRIDE = 12;
   localparam int GW_ROW_STRIDE = 3;
   localparam int GW_LB_ROWS    = GW_ROWS - 1;

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_ACTIVE = 1'b1
   } state_t;
endpackage

// File: rtl/gauss_window_gen_if.sv
// Pixel-in / window-out handshake bundle for gauss_window_gen.
interface gauss_window_gen_if
   import gauss_window_gen_pkg::*;
#(
   parameter int BIT_WIDTH = 8
) ();
   logic                                 in_valid;
   logic                                 in_ready;
   logic [BIT_WIDTH-1:0]                 in_pix;
   logic                                 in_sof;
   logic                                 out_valid;
   logic                                 out_ready;
   logic [GW_ROWS*GW_COLS*BIT_WIDTH-1:0] out_win;
   logic                                 out_eof;
   logic                                 err;

   modport master (
      output in_valid, in_pix, in_sof, out_ready,
      input  in_ready, out_valid, out_win, out_eof, err
   );

   modport slave (
      input  in_valid, in_pix, in_sof, out_ready,
      output in_ready, out_valid, out_win, out_eof, err
   );
endinterface

// File: rtl/gauss_window_gen_line_buf.sv
// gauss_line_buf: per-column store of the 4 previous rows; rd[0] is the newest row, rd[3] the oldest.
module gauss_line_buf
   import gauss_window_gen_pkg::*;
#(
   parameter  int BIT_WIDTH = 8,
   parameter  int IMG_W     = 26,
   localparam int CW        = $clog2(IMG_W)
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  we,
   input  logic [CW-1:0]                         col,
   input  logic [BIT_WIDTH-1:0]                  din,
   output logic [GW_LB_ROWS-1:0][BIT_WIDTH-1:0]  rd
);
   logic [GW_LB_ROWS-1:0][BIT_WIDTH-1:0] mem [IMG_W];

   assign rd = mem[col];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < IMG_W; i++) mem[i] <= '0;
      end else if (we) begin
         mem[col] <= {mem[col][GW_LB_ROWS-2:0], din};
      end
   end
endmodule

// File: rtl/gauss_window_gen.sv
// Raster pixel stream to 5x14 window producer (stride 12 cols / 3 rows).
// Optional GAUSS_WIN_ERR_EN: err pulses on a sof that does not fall on a frame boundary.
module gauss_window_gen
   import gauss_window_gen_pkg::*;
#(
   parameter int BIT_WIDTH = 8,
   parameter int IMG_W     = 26,
   parameter int IMG_H     = 8
) (
   input logic               clk,
   input logic               rst_n,
   gauss_window_gen_if.slave bus
);
   localparam int CW    = $clog2(IMG_W);
   localparam int RW    = $clog2(IMG_H);
   localparam int WIN_W = GW_ROWS * GW_COLS * BIT_WIDTH;

   state_t               state, state_nx;
   logic [CW-1:0]        col, col_nx, pix_c;
   logic [RW-1:0]        row, row_nx, pix_r;
   logic                 accept, take, emit, last;
   logic                 valid_q, eof_q, err_q;
   logic [WIN_W-1:0]     win_out_q, win_pack;
   logic [BIT_WIDTH-1:0] win_q  [GW_ROWS][GW_COLS];
   logic [BIT_WIDTH-1:0] win_nx [GW_ROWS][GW_COLS];
   logic [GW_LB_ROWS-1:0][BIT_WIDTH-1:0] lb_rd;

   assign bus.in_ready  = !valid_q || bus.out_ready;
   assign bus.out_valid = valid_q;
   assign bus.out_win   = win_out_q;
   assign bus.out_eof   = eof_q;
   assign bus.err       = err_q;
   assign accept        = bus.in_valid && bus.in_ready;

   gauss_line_buf #(.BIT_WIDTH(BIT_WIDTH), .IMG_W(IMG_W)) u_line_buf (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (take),
      .col   (pix_c),
      .din   (bus.in_pix),
      .rd    (lb_rd)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         row   <= '0;
         col   <= '0;
      end else begin
         state <= state_nx;
         row   <= row_nx;
         col   <= col_nx;
      end
   end

   // A sof pixel is always (0,0), in either state; that is the resync path.
   always_comb begin
      state_nx = state;
      row_nx   = row;
      col_nx   = col;
      pix_r    = bus.in_sof ? '0 : row;
      pix_c    = bus.in_sof ? '0 : col;
      take     = accept && (bus.in_sof || state == S_ACTIVE);
      last     = (pix_r == RW'(IMG_H-1)) && (pix_c == CW'(IMG_W-1));
      emit     = take
               && (int'(pix_r) >= GW_ROWS-1) && ((int'(pix_r) - (GW_ROWS-1)) % GW_ROW_STRIDE == 0)
               && (int'(pix_c) >= GW_COLS-1) && ((int'(pix_c) - (GW_COLS-1)) % GW_COL_STRIDE == 0);
      if (take) begin
         state_nx = S_ACTIVE;
         if (pix_c == CW'(IMG_W-1)) begin
            col_nx = '0;
            row_nx = last ? '0 : pix_r + RW'(1);
            if (last) state_nx = S_IDLE;
         end else begin
            col_nx = pix_c + CW'(1);
            row_nx = pix_r;
         end
      end
   end

   always_comb begin
      for (int unsigned r = 0; r < GW_ROWS; r++)
         for (int unsigned c = 0; c < GW_COLS-1; c++)
            win_nx[r][c] = win_q[r][c+1];
      for (int unsigned r = 0; r < GW_ROWS-1; r++)
         win_nx[r][GW_COLS-1] = lb_rd[GW_ROWS-2-r];
      win_nx[GW_ROWS-1][GW_COLS-1] = bus.in_pix;

      win_pack = '0;
      for (int unsigned r = 0; r < GW_ROWS; r++)
         for (int unsigned c = 0; c < GW_COLS; c++)
            win_pack[(GW_ROWS*GW_COLS - (GW_COLS*r + c))*BIT_WIDTH - 1 -: BIT_WIDTH] = win_nx[r][c];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned r = 0; r < GW_ROWS; r++)
            for (int unsigned c = 0; c < GW_COLS; c++)
               win_q[r][c] <= '0;
         valid_q   <= 1'b0;
         win_out_q <= '0;
         eof_q     <= 1'b0;
      end else begin
         if (take) win_q <= win_nx;
         if (emit) begin
            valid_q   <= 1'b1;
            win_out_q <= win_pack;
            eof_q     <= last;
         end else if (bus.out_ready) begin
            valid_q <= 1'b0;
            eof_q   <= 1'b0;
         end
      end
   end

`ifdef GAUSS_WIN_ERR_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_q <= 1'b0;
      else        err_q <= accept && bus.in_sof && (state == S_ACTIVE) && (row != '0 || col != '0);
   end
`else
   assign err_q = 1'b0;
`endif
endmodule
